// File: rtl/gen_ram_addr_ctrl_if.sv
// Channel request/acknowledge/status bundle for gen_ram_addr_ctrl.
// The err_clr/ovf_err/udf_err signals exist only when GEN_RAM_ERR_STICKY_EN is defined.
interface gen_ram_addr_ctrl_if #(
    parameter int NCH = 3,
    parameter int AW  = 5
);
    logic [NCH-1:0]       wren;
    logic [NCH-1:0]       rden;
    logic [NCH*AW-1:0]    wradd;
    logic [NCH*AW-1:0]    rdadd;
    logic [NCH-1:0]       wr_ack;
    logic [NCH-1:0]       rd_ack;
    logic [NCH*(AW+1)-1:0] level;
    logic [NCH-1:0]       full;
    logic [NCH-1:0]       empty;
`ifdef GEN_RAM_ERR_STICKY_EN
    logic [NCH-1:0]       err_clr;
    logic [NCH-1:0]       ovf_err;
    logic [NCH-1:0]       udf_err;

    modport master (
        output wren, rden, err_clr,
        input  wradd, rdadd, wr_ack, rd_ack, level, full, empty, ovf_err, udf_err
    );
    modport slave (
        input  wren, rden, err_clr,
        output wradd, rdadd, wr_ack, rd_ack, level, full, empty, ovf_err, udf_err
    );
`else
    modport master (
        output wren, rden,
        input  wradd, rdadd, wr_ack, rd_ack, level, full, empty
    );
    modport slave (
        input  wren, rden,
        output wradd, rdadd, wr_ack, rd_ack, level, full, empty
    );
`endif
endinterface

// File: rtl/gen_ram_addr_ctrl.sv
// Multi-channel circular-buffer address controller with per-channel pointers, level and full/empty.
// Define GEN_RAM_ERR_STICKY_EN to add sticky overflow/underflow error flags with per-channel clear.
module gen_ram_addr_ctrl #(
    parameter int NCH   = 3,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input logic clk,
    input logic aclr,
    gen_ram_addr_ctrl_if.slave bus
);

    logic [NCH-1:0][AW-1:0] wrPtr_q, wrPtr_d;
    logic [NCH-1:0][AW-1:0] rdPtr_q, rdPtr_d;
    logic [NCH-1:0][AW:0]   level_q, level_d;
    logic [NCH-1:0]         full_q, full_d;
    logic [NCH-1:0]         empty_q, empty_d;
    logic [NCH-1:0]         wrAck, rdAck;
`ifdef GEN_RAM_ERR_STICKY_EN
    logic [NCH-1:0]         ovf_q, ovf_d;
    logic [NCH-1:0]         udf_q, udf_d;
`endif

    // Wrap at DEPTH, which need not be a power of two, so the increment is done one bit wider.
    function automatic logic [AW-1:0] advance(input logic [AW-1:0] ptr);
        logic [AW:0] wide;
        wide = {1'b0, ptr} + (AW+1)'(1);
        if (wide == (AW+1)'(DEPTH))
            return '0;
        return wide[AW-1:0];
    endfunction

    always_comb begin
        wrAck   = '0;
        rdAck   = '0;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        full_d  = full_q;
        empty_d = empty_q;
`ifdef GEN_RAM_ERR_STICKY_EN
        ovf_d   = ovf_q & ~bus.err_clr;
        udf_d   = udf_q & ~bus.err_clr;
`endif
        for (int i = 0; i < NCH; i++) begin
            // A full channel still takes a write when a read frees a slot in the same cycle.
            rdAck[i] = bus.rden[i] & ~empty_q[i] & ~aclr;
            wrAck[i] = bus.wren[i] & (~full_q[i] | rdAck[i]) & ~aclr;
            if (wrAck[i])
                wrPtr_d[i] = advance(wrPtr_q[i]);
            if (rdAck[i])
                rdPtr_d[i] = advance(rdPtr_q[i]);
            case ({wrAck[i], rdAck[i]})
                2'b10:   level_d[i] = level_q[i] + (AW+1)'(1);
                2'b01:   level_d[i] = level_q[i] - (AW+1)'(1);
                default: level_d[i] = level_q[i];
            endcase
            full_d[i]  = (level_d[i] == (AW+1)'(DEPTH));
            empty_d[i] = (level_d[i] == '0);
`ifdef GEN_RAM_ERR_STICKY_EN
            if (bus.wren[i] & ~wrAck[i])
                ovf_d[i] = 1'b1;
            if (bus.rden[i] & ~rdAck[i])
                udf_d[i] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            full_q  <= '0;
            empty_q <= '1;
`ifdef GEN_RAM_ERR_STICKY_EN
            ovf_q   <= '0;
            udf_q   <= '0;
`endif
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
`ifdef GEN_RAM_ERR_STICKY_EN
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`endif
        end
    end

    // Packed channel arrays flatten so that channel i lands at [i*W +: W].
    assign bus.wradd  = wrPtr_q;
    assign bus.rdadd  = rdPtr_q;
    assign bus.level  = level_q;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.wr_ack = wrAck;
    assign bus.rd_ack = rdAck;
`ifdef GEN_RAM_ERR_STICKY_EN
    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`endif

endmodule

// File: tb/tb_gen_ram_addr_ctrl.sv
// Directed self-checking bench for gen_ram_addr_ctrl with NCH=3, AW=5, DEPTH=20.
// Sticky-error steps are compiled in only when GEN_RAM_ERR_STICKY_EN is defined.
module tb_gen_ram_addr_ctrl;

    localparam int NCH   = 3;
    localparam int AW    = 5;
    localparam int DEPTH = 20;

    logic clk = 1'b0;
    logic aclr;
    int   checks   = 0;
    int   failures = 0;

    gen_ram_addr_ctrl_if #(.NCH(NCH), .AW(AW)) bus ();

    gen_ram_addr_ctrl #(.NCH(NCH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land 1ns after it, clear of the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NCH-1:0] wr,
                                 input logic [NCH-1:0] rd, input logic [NCH-1:0] clr);
        aclr     = rst;
        bus.wren = wr;
        bus.rden = rd;
`ifdef GEN_RAM_ERR_STICKY_EN
        bus.err_clr = clr;
`else
        if (clr != '0)
            $display("[TB] note: err_clr ignored in this build");
`endif
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] wrA(input int ch);
        return 32'(bus.wradd[ch*AW +: AW]);
    endfunction
    function automatic logic [31:0] rdA(input int ch);
        return 32'(bus.rdadd[ch*AW +: AW]);
    endfunction
    function automatic logic [31:0] lvl(input int ch);
        return 32'(bus.level[ch*(AW+1) +: AW+1]);
    endfunction

    initial begin
        // 1: reset held two cycles with every request asserted
        applyStimulus(1'b1, 3'b111, 3'b111, 3'b000);
        tick(2);
        checkOutput("rst_wr_ack", 32'(bus.wr_ack), 0);
        checkOutput("rst_rd_ack", 32'(bus.rd_ack), 0);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("rst_wradd", 32'(bus.wradd), 0);
        checkOutput("rst_rdadd", 32'(bus.rdadd), 0);
        checkOutput("rst_level", 32'(bus.level), 0);
        checkOutput("rst_empty", 32'(bus.empty), 32'b111);
        checkOutput("rst_full",  32'(bus.full), 0);
`ifdef GEN_RAM_ERR_STICKY_EN
        checkOutput("rst_ovf", 32'(bus.ovf_err), 0);
        checkOutput("rst_udf", 32'(bus.udf_err), 0);
`endif

        // 2: fill channel 0
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 3'b001, 3'b000, 3'b000);
            checkOutput($sformatf("fill_wradd_%0d", k), wrA(0), 32'(k));
            checkOutput($sformatf("fill_ack_%0d", k), 32'(bus.wr_ack), 32'b001);
            if (k == DEPTH - 1)
                checkOutput("fill_full_before_last", 32'(bus.full[0]), 0);
            tick();
        end
        checkOutput("fill_full", 32'(bus.full[0]), 1);
        checkOutput("fill_level", lvl(0), DEPTH);
        checkOutput("fill_wradd_wrap", wrA(0), 0);
        checkOutput("fill_not_empty", 32'(bus.empty[0]), 0);
        applyStimulus(1'b0, 3'b001, 3'b000, 3'b000);
        checkOutput("ovf_wr_ack", 32'(bus.wr_ack), 0);
        tick();
        checkOutput("ovf_wradd_hold", wrA(0), 0);
        checkOutput("ovf_level_hold", lvl(0), DEPTH);

`ifdef GEN_RAM_ERR_STICKY_EN
        // 6: sticky errors
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("ovf_set", 32'(bus.ovf_err), 32'b001);
        tick();
        checkOutput("ovf_held", 32'(bus.ovf_err), 32'b001);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b001);
        tick();
        checkOutput("ovf_cleared", 32'(bus.ovf_err), 0);
        applyStimulus(1'b0, 3'b001, 3'b000, 3'b001);
        tick();
        checkOutput("ovf_set_beats_clr", 32'(bus.ovf_err), 32'b001);
        applyStimulus(1'b0, 3'b000, 3'b010, 3'b001);
        checkOutput("udf_rd_ack", 32'(bus.rd_ack), 0);
        tick();
        checkOutput("udf_set", 32'(bus.udf_err), 32'b010);
        checkOutput("ovf_clr2", 32'(bus.ovf_err), 0);
        applyStimulus(1'b0, 3'b000, 3'b010, 3'b010);
        tick();
        checkOutput("udf_set_beats_clr", 32'(bus.udf_err), 32'b010);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b010);
        tick();
        checkOutput("udf_cleared", 32'(bus.udf_err), 0);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
`endif

        // 3: channel 1 interleaved write/read wraps the read pointer
        for (int k = 0; k < 25; k++) begin
            applyStimulus(1'b0, 3'b010, 3'b000, 3'b000);
            tick();
            applyStimulus(1'b0, 3'b000, 3'b010, 3'b000);
            checkOutput($sformatf("wrap_rdadd_%0d", k), rdA(1), 32'(k % DEPTH));
            checkOutput($sformatf("wrap_rd_ack_%0d", k), 32'(bus.rd_ack), 32'b010);
            checkOutput($sformatf("wrap_level_%0d", k), lvl(1), 1);
            tick();
        end
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("wrap_level_end", lvl(1), 0);
        checkOutput("wrap_empty_end", 32'(bus.empty[1]), 1);
        checkOutput("wrap_rdadd_end", rdA(1), 5);
        checkOutput("wrap_wradd_end", wrA(1), 5);

        // 4: simultaneous write+read on channel 2 at full, then at empty
        applyStimulus(1'b0, 3'b100, 3'b000, 3'b000);
        tick(DEPTH);
        applyStimulus(1'b0, 3'b100, 3'b100, 3'b000);
        checkOutput("sim_full_wr_ack", 32'(bus.wr_ack), 32'b100);
        checkOutput("sim_full_rd_ack", 32'(bus.rd_ack), 32'b100);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("sim_full_level", lvl(2), DEPTH);
        checkOutput("sim_full_wradd", wrA(2), 1);
        checkOutput("sim_full_rdadd", rdA(2), 1);
        checkOutput("sim_full_flag", 32'(bus.full[2]), 1);
        applyStimulus(1'b0, 3'b000, 3'b100, 3'b000);
        tick(DEPTH);
        applyStimulus(1'b0, 3'b100, 3'b100, 3'b000);
        checkOutput("sim_empty_wr_ack", 32'(bus.wr_ack), 32'b100);
        checkOutput("sim_empty_rd_ack", 32'(bus.rd_ack), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("sim_empty_level", lvl(2), 1);
        checkOutput("sim_empty_wradd", wrA(2), 2);
        checkOutput("sim_empty_rdadd", rdA(2), 1);
        checkOutput("sim_empty_flag", 32'(bus.empty[2]), 0);

        // 5: reset in the middle of operation on channel 0
        applyStimulus(1'b1, 3'b000, 3'b000, 3'b000);
        tick();
        applyStimulus(1'b0, 3'b001, 3'b000, 3'b000);
        tick(7);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("mid_level", lvl(0), 7);
        checkOutput("mid_wradd", wrA(0), 7);
        checkOutput("mid_rdadd", rdA(0), 0);
        applyStimulus(1'b1, 3'b111, 3'b000, 3'b000);
        checkOutput("mid_rst_wr_ack", 32'(bus.wr_ack), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
        checkOutput("mid_rst_wradd", 32'(bus.wradd), 0);
        checkOutput("mid_rst_rdadd", 32'(bus.rdadd), 0);
        checkOutput("mid_rst_level", 32'(bus.level), 0);
        checkOutput("mid_rst_empty", 32'(bus.empty), 32'b111);
        checkOutput("mid_rst_full", 32'(bus.full), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
